// File: rtl/line_refill.sv
// Miss engine for one cache line: writes a dirty victim back word by word,
// then refills the line from word-wide main memory.
module line_refill #(
    parameter int TAG_WIDTH    = 20,
    parameter int SET_WIDTH    = 8,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [TAG_WIDTH-1:0]    miss_tag,
    input  logic [SET_WIDTH-1:0]    miss_index,
    input  logic [TAG_WIDTH-1:0]    victim_tag,
    input  logic                    victim_dirty,
    output logic                    busy,
    output logic                    done,
    output logic [OFFSET_WIDTH-3:0] line_offset,
    output logic                    line_w_en,
    output logic                    line_set_valid,
    output logic                    line_set_dirty,
    output logic [TAG_WIDTH-1:0]    line_set_tag,
    output logic [31:0]             line_write_data,
    input  logic [31:0]             line_read_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_ready,
    input  logic [31:0]             mem_rdata
);

    localparam int CNT_WIDTH = OFFSET_WIDTH - 2;
    localparam logic [CNT_WIDTH-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        RF,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic [TAG_WIDTH-1:0]   mtag_q;
    logic [TAG_WIDTH-1:0]   vtag_q;
    logic [SET_WIDTH-1:0]   index_q;

    // Request fields are captured only when a transaction is accepted in IDLE,
    // so the cache may change them freely while we are busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            mtag_q  <= '0;
            vtag_q  <= '0;
            index_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && start) begin
                mtag_q  <= miss_tag;
                vtag_q  <= victim_tag;
                index_q <= miss_index;
            end
        end
    end

    assign line_set_tag   = mtag_q;
    assign line_set_dirty = 1'b0;

    // Reset forces the strobes low in the same cycle so a mid-transaction
    // reset can never issue a stray line write or memory request.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        busy            = 1'b0;
        done            = 1'b0;
        line_offset     = cnt;
        line_w_en       = 1'b0;
        line_set_valid  = 1'b0;
        line_write_data = '0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        if (!reset) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_next   = '0;
                        state_next = victim_dirty ? WB : RF;
                    end
                end
                WB: begin
                    busy      = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {vtag_q, index_q, cnt, 2'b00};
                    mem_wdata = line_read_data;
                    if (mem_ready) begin
                        cnt_next = cnt + 1'b1;
                        if (cnt == LAST_WORD) begin
                            state_next = RF;
                        end
                    end
                end
                RF: begin
                    busy     = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {mtag_q, index_q, cnt, 2'b00};
                    if (mem_ready) begin
                        line_w_en       = 1'b1;
                        line_write_data = mem_rdata;
                        line_set_valid  = (cnt == LAST_WORD);
                        cnt_next        = cnt + 1'b1;
                        if (cnt == LAST_WORD) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    busy       = 1'b1;
                    done       = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_refill.sv
// Bench for line_refill: the bench plays both main memory and the line storage,
// and checks each transaction's memory traffic, latency and final line contents.
module tb_line_refill;

    localparam int TW    = 20;
    localparam int SW    = 8;
    localparam int OW    = 4;
    localparam int WORDS = 4;

    logic            clk          = 1'b0;
    logic            reset        = 1'b1;
    logic            start        = 1'b0;
    logic [TW-1:0]   miss_tag     = '0;
    logic [SW-1:0]   miss_index   = '0;
    logic [TW-1:0]   victim_tag   = '0;
    logic            victim_dirty = 1'b0;
    logic            busy;
    logic            done;
    logic [OW-3:0]   line_offset;
    logic            line_w_en;
    logic            line_set_valid;
    logic            line_set_dirty;
    logic [TW-1:0]   line_set_tag;
    logic [31:0]     line_write_data;
    logic [31:0]     line_read_data;
    logic            mem_req;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic            mem_ready    = 1'b0;
    logic [31:0]     mem_rdata    = '0;

    line_refill #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .OFFSET_WIDTH(OW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .miss_tag(miss_tag), .miss_index(miss_index),
        .victim_tag(victim_tag), .victim_dirty(victim_dirty),
        .busy(busy), .done(done),
        .line_offset(line_offset), .line_w_en(line_w_en),
        .line_set_valid(line_set_valid), .line_set_dirty(line_set_dirty),
        .line_set_tag(line_set_tag), .line_write_data(line_write_data),
        .line_read_data(line_read_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        bit          dirty;
        int          waits;
        logic [TW-1:0] mtag;
        logic [SW-1:0] idx;
        logic [TW-1:0] vtag;
        logic [31:0] vbase;
        logic [31:0] salt;
        bit          noise;
        int          exp_lat;
    } vec_t;

    logic [31:0]   line_data [WORDS];
    logic          line_valid;
    logic [TW-1:0] line_tag;
    assign line_read_data = line_data[line_offset];

    xfer_t       xlog[$];
    int          vectors      = 0;
    int          miscompares  = 0;
    int          cyc          = 0;
    int          done_pulses  = 0;
    int          valid_writes = 0;
    int          dirty_writes = 0;
    bit          rst_next     = 1'b1;
    int          cur_waits    = 0;
    logic [31:0] cur_salt     = '0;
    bit          in_word      = 1'b0;
    int          wait_cnt     = 0;
    logic        hold_we;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    bit          pend_w       = 1'b0;
    logic [1:0]  pend_off;
    logic [31:0] pend_data;
    logic        pend_valid;
    logic [TW-1:0] pend_tag;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One clock cycle: apply reset, commit last cycle's line write, answer memory
    // (a word is acked after cur_waits idle cycles), then capture this cycle's line write.
    task automatic tick();
        @(negedge clk);
        cyc++;
        reset = rst_next;
        if (pend_w) begin
            line_data[pend_off] = pend_data;
            line_valid          = pend_valid;
            line_tag            = pend_tag;
            pend_w              = 1'b0;
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        #1;
        if (mem_req) begin
            if (!in_word) begin
                in_word    = 1'b1;
                wait_cnt   = 0;
                hold_we    = mem_we;
                hold_addr  = mem_addr;
                hold_wdata = mem_wdata;
            end else begin
                checkOutput("hold_addr", mem_addr, hold_addr);
                checkOutput("hold_wdata", mem_wdata, hold_wdata);
                checkOutput("hold_we", 32'(mem_we), 32'(hold_we));
            end
            if (wait_cnt == cur_waits) begin
                mem_ready = 1'b1;
                mem_rdata = cur_salt + 32'(mem_addr[3:2]) + 32'd1;
                xlog.push_back(xfer_t'{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
                in_word = 1'b0;
            end else begin
                wait_cnt++;
            end
        end else begin
            in_word = 1'b0;
        end
        #1;
        if (done) done_pulses++;
        if (line_w_en) begin
            checkOutput("w_en_without_ready", 32'(mem_ready), 32'd1);
            pend_w     = 1'b1;
            pend_off   = line_offset;
            pend_data  = line_write_data;
            pend_valid = line_set_valid;
            pend_tag   = line_set_tag;
            if (line_set_valid) valid_writes++;
            if (line_set_dirty) dirty_writes++;
        end
    endtask

    task automatic preloadLine(input logic [31:0] vbase, input logic [TW-1:0] vtag);
        for (int i = 0; i < WORDS; i++) line_data[i] = vbase + 32'(i);
        line_valid = 1'b1;
        line_tag   = vtag;
    endtask

    // Runs one miss and compares everything against the expected transaction
    // derived from the request: optional write-back of the victim, then the refill.
    task automatic applyStimulus(input vec_t v);
        xfer_t exp_q[$];
        int    c0;
        int    lat;
        bit    busy_ok;
        bit    got_done;
        int    n;
        preloadLine(v.vbase, v.vtag);
        xlog.delete();
        valid_writes = 0;
        dirty_writes = 0;
        in_word      = 1'b0;
        cur_waits    = v.waits;
        cur_salt     = v.salt;
        miss_tag     = v.mtag;
        miss_index   = v.idx;
        victim_tag   = v.vtag;
        victim_dirty = v.dirty;
        start        = 1'b1;
        c0       = cyc;
        busy_ok  = 1'b1;
        got_done = 1'b0;
        lat      = 0;
        for (int k = 0; k < 300 && !got_done; k++) begin
            tick();
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                got_done = 1'b1;
                lat      = cyc - c0 + 1;
                start    = 1'b0;
            end else if (v.noise) begin
                start        = 1'($urandom);
                miss_tag     = TW'($urandom);
                miss_index   = SW'($urandom);
                victim_tag   = TW'($urandom);
                victim_dirty = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        checkOutput("done_seen", 32'(got_done), 32'd1);
        checkOutput("latency", 32'(lat), 32'(v.exp_lat));
        checkOutput("busy_during", 32'(busy_ok), 32'd1);
        tick();
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("done_after", 32'(done), 32'd0);

        if (v.dirty) begin
            for (int i = 0; i < WORDS; i++)
                exp_q.push_back(xfer_t'{1'b1, {v.vtag, v.idx, 2'(i), 2'b00}, v.vbase + 32'(i)});
        end
        for (int i = 0; i < WORDS; i++)
            exp_q.push_back(xfer_t'{1'b0, {v.mtag, v.idx, 2'(i), 2'b00}, v.salt + 32'(i) + 32'd1});
        checkOutput("xfer_count", 32'(xlog.size()), 32'(exp_q.size()));
        n = (xlog.size() < exp_q.size()) ? xlog.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("xfer%0d_we", i), 32'(xlog[i].we), 32'(exp_q[i].we));
            checkOutput($sformatf("xfer%0d_addr", i), xlog[i].addr, exp_q[i].addr);
            checkOutput($sformatf("xfer%0d_data", i), xlog[i].data, exp_q[i].data);
        end
        for (int i = 0; i < WORDS; i++)
            checkOutput($sformatf("line_word%0d", i), line_data[i], v.salt + 32'(i) + 32'd1);
        checkOutput("line_valid", 32'(line_valid), 32'd1);
        checkOutput("line_tag", 32'(line_tag), 32'(v.mtag));
        checkOutput("valid_writes", 32'(valid_writes), 32'd1);
        checkOutput("dirty_writes", 32'(dirty_writes), 32'd0);
    endtask

    // Reset lands while the second refill word is on the bus.
    task automatic resetMidRefill();
        int d0;
        preloadLine(32'h0, 20'h0BEEF);
        xlog.delete();
        valid_writes = 0;
        cur_waits    = 0;
        cur_salt     = 32'h40;
        miss_tag     = 20'hC0FFE;
        miss_index   = 8'h3C;
        victim_dirty = 1'b0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("rst_pre_w_en", 32'(line_w_en), 32'd1);
        rst_next = 1'b1;
        tick();
        rst_next = 1'b0;
        tick();
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_w_en", 32'(line_w_en), 32'd0);
        d0 = done_pulses;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("rst_no_done", 32'(done_pulses - d0), 32'd0);
        checkOutput("rst_valid_writes", 32'(valid_writes), 32'd0);
        checkOutput("rst_line_invalid", 32'(line_valid), 32'd0);
    endtask

    // start held high straight through DONE: two transactions, separated by an IDLE cycle.
    task automatic backToBack();
        bit eb[12] = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        bit ed[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        int d0;
        preloadLine(32'h0, 20'h0);
        xlog.delete();
        cur_waits    = 0;
        cur_salt     = 32'h0;
        miss_tag     = 20'h2A2A2;
        miss_index   = 8'h77;
        victim_dirty = 1'b0;
        start        = 1'b1;
        d0 = done_pulses;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            checkOutput($sformatf("b2b_busy%0d", i), 32'(busy), 32'(eb[i]));
            checkOutput($sformatf("b2b_done%0d", i), 32'(done), 32'(ed[i]));
        end
        start = 1'b0;
        tick();
        checkOutput("b2b_busy_end", 32'(busy), 32'd0);
        checkOutput("b2b_done_count", 32'(done_pulses - d0), 32'd2);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        for (int i = 0; i < WORDS; i++) line_data[i] = '0;
        line_valid = 1'b0;
        line_tag   = '0;

        tbl[0] = '{1'b0, 0, 20'hABCDE, 8'h12, 20'h00000, 32'h0,    32'h0,   1'b0, 6};
        tbl[1] = '{1'b1, 0, 20'hABCDE, 8'h12, 20'h11111, 32'hA0,   32'h0,   1'b0, 10};
        tbl[2] = '{1'b0, 3, 20'hABCDE, 8'h12, 20'h11111, 32'h0,    32'h0,   1'b0, 18};
        tbl[3] = '{1'b1, 3, 20'h0F0F0, 8'h34, 20'h2468A, 32'h1000, 32'h100, 1'b0, 34};
        tbl[4] = '{1'b0, 0, 20'h12345, 8'h56, 20'h54321, 32'h0,    32'h200, 1'b1, 6};
        tbl[5] = '{1'b1, 1, 20'hFFFFF, 8'hFF, 20'h00001, 32'h55,   32'h300, 1'b1, 18};

        rst_next = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_w_en", 32'(line_w_en), 32'd0);
        rst_next = 1'b0;
        tick();
        checkOutput("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] table vector %0d", i);
            applyStimulus(tbl[i]);
        end

        resetMidRefill();
        backToBack();

        for (int i = 0; i < 25; i++) begin
            v.dirty   = 1'($urandom);
            v.waits   = int'($urandom_range(0, 2));
            v.mtag    = TW'($urandom);
            v.idx     = SW'($urandom);
            v.vtag    = TW'($urandom);
            v.vbase   = $urandom;
            v.salt    = $urandom;
            v.noise   = 1'($urandom);
            v.exp_lat = 2 + (v.dirty ? 2 : 1) * WORDS * (v.waits + 1);
            applyStimulus(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
